// File: rtl/intc_err_arb_if.sv
// Bus between the error-interrupt arbiter and its environment: latched
// error lines and CPU handshake in, request/vector/clear pulse out.
interface intc_err_arb_if;
  // Handshake: err_req_o stays high until a one-cycle cpu_ack_i is seen
  // (no ready/valid back-pressure). cpu_eoi_i is then accepted only in
  // service. eirqc_o is a one-cycle clear pulse with no acknowledge.
  logic [7:0] eirq_i;
  logic [7:0] eimk_i;
  logic       rr_en_i;
  logic       cpu_ack_i;
  logic       cpu_eoi_i;
  logic       tmo_clr_i;
  logic       err_req_o;
  logic [7:0] err_vec_o;
  logic [2:0] err_id_o;
  logic [7:0] eirqc_o;
  logic       busy_o;
  logic       tmo_o;

  modport slave (
    input  eirq_i, eimk_i, rr_en_i, cpu_ack_i, cpu_eoi_i, tmo_clr_i,
    output err_req_o, err_vec_o, err_id_o, eirqc_o, busy_o, tmo_o
  );

  modport master (
    output eirq_i, eimk_i, rr_en_i, cpu_ack_i, cpu_eoi_i, tmo_clr_i,
    input  err_req_o, err_vec_o, err_id_o, eirqc_o, busy_o, tmo_o
  );
endinterface

// File: rtl/intc_err_arb.sv
// Error-interrupt arbiter: picks one pending unmasked source (fixed or
// round-robin), runs the ack/eoi handshake and emits a one-cycle clear.
module intc_err_arb #(
  parameter logic [7:0]  VEC_BASE = 8'h40,
  parameter int          TMO_W    = 8,
  parameter int unsigned ACK_TMO  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  intc_err_arb_if.slave     bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, REQ, SRV, CLR} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [TMO_W-1:0] cnt;

  logic [7:0]       elig;
  logic [2:0]       start;
  logic [2:0]       idx;
  logic [2:0]       win;
  logic             found;
  logic [TMO_W-1:0] cnt_inc;
  logic             tmo_hit;
  logic             withdraw;
  logic             tmo_fire;
  logic [2:0]       nxt_ptr;

  assign dbg_state = state;
  assign elig      = bus.eirq_i & ~bus.eimk_i;
  assign start     = bus.rr_en_i ? ptr : 3'd0;

  // Scan from the start index with 3-bit wrap; fixed priority is start = 0.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign cnt_inc  = (cnt == {TMO_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign tmo_hit  = (ACK_TMO != 0) && (cnt_inc >= TMO_W'(ACK_TMO));
  assign withdraw = !bus.eirq_i[bus.err_id_o] || bus.eimk_i[bus.err_id_o];
  // Ack outranks withdraw, which outranks the timeout.
  assign tmo_fire = (state == REQ) && !bus.cpu_ack_i && !withdraw && tmo_hit;
  assign nxt_ptr  = bus.err_id_o + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      cnt           <= '0;
      bus.err_req_o <= 1'b0;
      bus.err_vec_o <= 8'd0;
      bus.err_id_o  <= 3'd0;
      bus.eirqc_o   <= 8'd0;
      bus.busy_o    <= 1'b0;
      bus.tmo_o     <= 1'b0;
    end else begin
      if (tmo_fire)
        bus.tmo_o <= 1'b1;
      else if (bus.tmo_clr_i)
        bus.tmo_o <= 1'b0;

      case (state)
        IDLE: begin
          if (found) begin
            bus.err_id_o  <= win;
            bus.err_vec_o <= VEC_BASE + {5'd0, win};
            bus.err_req_o <= 1'b1;
            bus.busy_o    <= 1'b1;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.cpu_ack_i) begin
            bus.err_req_o <= 1'b0;
            cnt           <= '0;
            state         <= SRV;
          end else if (withdraw || tmo_fire) begin
            bus.err_req_o <= 1'b0;
            bus.busy_o    <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
            if (bus.rr_en_i) ptr <= nxt_ptr;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SRV: begin
          if (bus.cpu_eoi_i) begin
            bus.eirqc_o <= 8'd1 << bus.err_id_o;
            state       <= CLR;
          end
        end
        CLR: begin
          bus.eirqc_o <= 8'd0;
          bus.busy_o  <= 1'b0;
          state       <= IDLE;
          if (bus.rr_en_i) ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_err_arb.sv
// Bench for intc_err_arb: directed vector table, async-reset sequence,
// then randomized traffic against a cycle-level reference model.
module tb_intc_err_arb;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  intc_err_arb_if bus ();

  intc_err_arb #(.VEC_BASE(8'h40), .TMO_W(8), .ACK_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [21:0] act;
  assign act = {bus.err_req_o, bus.err_vec_o, bus.err_id_o, bus.eirqc_o,
                bus.busy_o, bus.tmo_o};

  typedef struct {
    logic [7:0] eirq;
    logic [7:0] eimk;
    logic       rr, ack, eoi, tc;
    logic       req;
    logic [7:0] vec;
    logic [2:0] id;
    logic [7:0] clr;
    logic       busy, tmo;
  } vec_t;

  vec_t        tbl[$];
  logic [21:0] exp_q[$];

  task automatic chk(input string name, input logic [21:0] a, input logic [21:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic drive(input logic [7:0] eirq, input logic [7:0] eimk, input logic rr,
                       input logic ack, input logic eoi, input logic tc);
    bus.eirq_i = eirq; bus.eimk_i = eimk; bus.rr_en_i = rr;
    bus.cpu_ack_i = ack; bus.cpu_eoi_i = eoi; bus.tmo_clr_i = tc;
  endtask

  task automatic add(input logic [7:0] eirq, input logic [7:0] eimk, input logic rr,
                     input logic ack, input logic eoi, input logic tc,
                     input logic req, input logic [7:0] vec, input logic [2:0] id,
                     input logic [7:0] clr, input logic busy, input logic tmo);
    vec_t v;
    v.eirq = eirq; v.eimk = eimk; v.rr = rr; v.ack = ack; v.eoi = eoi; v.tc = tc;
    v.req = req; v.vec = vec; v.id = id; v.clr = clr; v.busy = busy; v.tmo = tmo;
    tbl.push_back(v);
  endtask

  // Reference model: phase 0 idle, 1 requesting, 2 in service, 3 clearing.
  int m_ph, m_ptr, m_id, m_vec, m_clr, m_cnt;
  bit m_req, m_busy, m_tmo;

  function automatic int pick(input int elig, input int from);
    for (int k = 0; k < 8; k++)
      if (((elig >> ((from + k) % 8)) & 1) != 0) return (from + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_id = 0; m_vec = 0; m_clr = 0; m_cnt = 0;
    m_req = 0; m_busy = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    int  e, mk, w, c;
    bit  leave, tout;
    e = int'(bus.eirq_i); mk = int'(bus.eimk_i);
    leave = 0; tout = 0;
    case (m_ph)
      0: begin
        w = pick(e & ~mk & 255, bus.rr_en_i ? m_ptr : 0);
        if (w >= 0) begin
          m_id = w; m_vec = (64 + w) % 256; m_req = 1; m_ph = 1; m_cnt = 0;
        end
      end
      1: begin
        if (bus.cpu_ack_i) begin
          m_ph = 2; m_req = 0; m_cnt = 0;
        end else if (((e >> m_id) & 1) == 0 || ((mk >> m_id) & 1) == 1) begin
          leave = 1;
        end else begin
          c = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          if (c >= TMO) begin leave = 1; tout = 1; end
          else m_cnt = c;
        end
        if (leave) begin m_ph = 0; m_req = 0; m_cnt = 0; end
      end
      2: if (bus.cpu_eoi_i) begin m_ph = 3; m_clr = 1 << m_id; end
      default: begin m_ph = 0; m_clr = 0; leave = 1; end
    endcase
    if (leave && bus.rr_en_i) m_ptr = (m_id + 1) % 8;
    if (tout) m_tmo = 1;
    else if (bus.tmo_clr_i) m_tmo = 0;
    m_busy = (m_ph != 0);
  endtask

  function automatic logic [21:0] model_out();
    return {m_req, 8'(m_vec), 3'(m_id), 8'(m_clr), m_busy, m_tmo};
  endfunction

  initial begin
    vec_t v;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fixed priority, withdraw, handshake corners, timeout, round-robin.
    add(8'h24,8'h00,0,0,0,0, 1,8'h42,2,8'h00,1,0);
    add(8'h24,8'h00,0,1,0,0, 0,8'h42,2,8'h00,1,0);
    add(8'h24,8'h00,0,0,0,0, 0,8'h42,2,8'h00,1,0);
    add(8'h24,8'h00,0,0,1,0, 0,8'h42,2,8'h04,1,0);
    add(8'h00,8'h00,0,0,0,0, 0,8'h42,2,8'h00,0,0);
    add(8'h00,8'h00,0,0,1,0, 0,8'h42,2,8'h00,0,0);
    add(8'h08,8'h00,0,1,0,0, 1,8'h43,3,8'h00,1,0);
    add(8'h08,8'h08,0,0,0,0, 0,8'h43,3,8'h00,0,0);
    add(8'h0A,8'h08,0,0,0,0, 1,8'h41,1,8'h00,1,0);
    add(8'h0A,8'h08,0,1,1,0, 0,8'h41,1,8'h00,1,0);
    add(8'h0A,8'h08,0,1,0,0, 0,8'h41,1,8'h00,1,0);
    add(8'h0A,8'h08,0,0,1,0, 0,8'h41,1,8'h02,1,0);
    add(8'h00,8'h00,0,0,0,0, 0,8'h41,1,8'h00,0,0);
    add(8'h01,8'h00,0,0,0,0, 1,8'h40,0,8'h00,1,0);
    for (int i = 0; i < 3; i++) add(8'h01,8'h00,0,0,0,0, 1,8'h40,0,8'h00,1,0);
    add(8'h01,8'h00,0,0,0,0, 0,8'h40,0,8'h00,0,1);
    add(8'h01,8'h00,0,0,0,0, 1,8'h40,0,8'h00,1,1);
    add(8'h01,8'h00,0,0,0,1, 1,8'h40,0,8'h00,1,0);
    add(8'h01,8'h00,0,0,0,0, 1,8'h40,0,8'h00,1,0);
    add(8'h01,8'h00,0,0,0,0, 1,8'h40,0,8'h00,1,0);
    add(8'h01,8'h00,0,0,0,1, 0,8'h40,0,8'h00,0,1);
    add(8'h00,8'h00,0,0,0,0, 0,8'h40,0,8'h00,0,1);
    for (int r = 0; r < 2; r++) begin
      add(8'h81,8'h00,1,0,0,0, 1,8'h40,0,8'h00,1,1);
      add(8'h81,8'h00,1,1,0,0, 0,8'h40,0,8'h00,1,1);
      add(8'h81,8'h00,1,0,1,0, 0,8'h40,0,8'h01,1,1);
      add(8'h81,8'h00,1,0,0,0, 0,8'h40,0,8'h00,0,1);
      add(8'h81,8'h00,1,0,0,0, 1,8'h47,7,8'h00,1,1);
      add(8'h81,8'h00,1,1,0,0, 0,8'h47,7,8'h00,1,1);
      if (r == 0) begin
        add(8'h81,8'h00,1,0,1,0, 0,8'h47,7,8'h80,1,1);
        add(8'h81,8'h00,1,0,0,0, 0,8'h47,7,8'h00,0,1);
      end
    end

    repeat (3) @(posedge clk);
    #1 chk("reset_state", act, 22'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.eirq, v.eimk, v.rr, v.ack, v.eoi, v.tc);
      @(posedge clk); #1;
      chk($sformatf("vec_row_%0d", i), act,
          {v.req, v.vec, v.id, v.clr, v.busy, v.tmo});
    end

    // Bench is now in service for id 7: reset between edges.
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("async_reset_in_srv", act, 22'd0);
    drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_id4", act, {1'b1, 8'h44, 3'd4, 8'h00, 1'b1, 1'b0});

    // Randomized traffic against the model.
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] eirq;
      eirq = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bus.eirq_i;
      drive(eirq,
            ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00,
            ($urandom_range(0, 31) == 0) ? ~bus.rr_en_i : bus.rr_en_i,
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0));
      model_step();
      exp_q.push_back(model_out());
      @(posedge clk); #1;
      chk($sformatf("rand_cycle_%0d", n), act, exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intc_err_arb.md
Name: intc_err_arb

Overview:
Arbitration and service sequencer for the 8 latched error-interrupt lines of the interrupt controller. It selects one pending, unmasked error source using fixed or round-robin priority, and drives a single request/vector to the CPU. It tracks the acknowledge and end-of-service handshake, then issues a one-cycle clear pulse that software or the register block ORs into the error-interrupt-clear path. An acknowledge timeout watchdog sets a sticky flag.

Parameters:
VEC_BASE, 8'h40, vector number of error source 0; vector = VEC_BASE + id, 8-bit wrap.
TMO_W, 8, width of the acknowledge-timeout counter.
ACK_TMO, 255, cycles allowed in REQ without ack; 0 disables the timeout; must be ≤ 2^TMO_W-1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
eirq_i  in  8  latched pending error interrupts
eimk_i  in  8  error mask, 1 = source ineligible
rr_en_i  in  1  1 = round-robin, 0 = fixed priority (bit 0 highest)
cpu_ack_i  in  1  CPU acknowledge pulse
cpu_eoi_i  in  1  CPU end-of-service pulse
tmo_clr_i  in  1  clears tmo_o
err_req_o  out  1  error interrupt request to CPU
err_vec_o  out  8  vector of the selected source
err_id_o  out  3  index of the selected source
eirqc_o  out  8  one-hot clear pulse for the serviced source
busy_o  out  1  FSM not in IDLE
tmo_o  out  1  sticky acknowledge-timeout flag

Behaviour:
- Reset: all outputs 0, FSM = IDLE, rr pointer ptr = 0, timeout counter = 0.
- Eligibility: elig = eirq_i & ~eimk_i, evaluated combinationally in IDLE only.
- Winner selection:
  - Fixed priority: lowest set index of elig.
  - Round-robin: first set bit searching ptr, ptr+1, … wrapping mod 8.
- All outputs are registered.
- FSM states: IDLE, REQ, SRV, CLR.
- IDLE:
  - If elig != 0: latch id into err_id_o and VEC_BASE+id into err_vec_o, then go to REQ.
  - err_req_o rises in the cycle after elig is seen (1-cycle latency).
- REQ:
  - err_req_o = 1 and the counter increments each cycle.
  - Priority order: cpu_ack_i > withdraw > timeout.
  - cpu_ack_i → SRV, err_req_o = 0 next cycle, counter cleared.
  - Withdraw (eirq_i[id] = 0 or eimk_i[id] = 1) → IDLE, no clear pulse.
  - Timeout (ACK_TMO != 0 and counter reaches ACK_TMO) → IDLE, tmo_o set, no clear pulse.
- SRV: wait for cpu_eoi_i, then go to CLR. Source withdrawal in SRV is ignored.
- CLR: eirqc_o = 1 << id for exactly one cycle, then IDLE.
- Round-robin pointer:
  - ptr <= id+1 (mod 8) on leaving CLR, timeout or withdraw.
  - Only updated when rr_en_i = 1; otherwise ptr is unchanged.
  - A change of rr_en_i takes effect at the next IDLE arbitration.
- Ignored pulses: cpu_ack_i outside REQ; cpu_eoi_i outside SRV; cpu_eoi_i coincident with ack in REQ.
- Turnaround: after CLR, next arbitration happens in IDLE, so there is a minimum 1 IDLE cycle between consecutive requests.
- err_id_o / err_vec_o hold their last latched value in IDLE.
- busy_o = (state != IDLE).
- tmo_o: set on timeout, cleared by tmo_clr_i; set wins when both occur in the same cycle.
- Counter saturates at 2^TMO_W-1 and clears on entering REQ.
- rst_n assertion mid-transaction:
  - Immediately returns to IDLE and zeros all outputs.
  - Any pending eirqc_o pulse is lost.

Test Plan:
- Fixed priority: rr_en_i=0, eirq_i=8'h24, eimk_i=0 → err_req_o at cycle+1, err_id_o=2, err_vec_o=8'h42; ack then eoi → eirqc_o=8'h04 for one cycle, then IDLE.
- Round-robin: rr_en_i=1, eirq_i=8'h81 held, each grant completed → grant order 0,7,0,7; ptr advances to id+1 after each CLR.
- Mask/withdraw: in REQ for id 3, set eimk_i=8'h08 → err_req_o drops next cycle, eirqc_o stays 0, next arbitration excludes 3.
- Timeout: ACK_TMO=4, no ack → after 4 REQ cycles FSM returns to IDLE, tmo_o=1; tmo_clr_i with a new timeout in the same cycle → tmo_o stays 1.
- Handshake corner cases: eoi in REQ with ack → SRV only, no CLR; stray eoi in IDLE → no effect; ack in SRV → no effect.
- Async reset: assert rst_n=0 during SRV between clock edges → outputs 0 immediately; after release with eirq_i=8'h10 → id 4 requested.
